usb_packet_fifo: RTL

Parametrised packet-aware FIFO, the next generation of the USB endpoint data buffer. It sits between the USB protocol engine and the host-side register interface, and one instance serves either RX or TX.
- Adds write-side commit/abort, so a packet with a CRC or PID error is discarded atomically.
- Adds read-side ack/retry, so a TX packet can be retransmitted after a NAK or timeout.
- Adds sticky overflow and underflow error flags.

---
 rtl/usb_packet_fifo_pkg.sv | 17 +
 rtl/usb_packet_fifo_if.sv | 35 +++
 rtl/usb_packet_fifo_mem.sv | 26 ++
 rtl/usb_packet_fifo.sv | 102 ++++++++++
 4 files changed

// File: rtl/usb_packet_fifo_pkg.sv
// Shared defaults and pointer arithmetic for the USB packet FIFO.
package usb_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 64;
    localparam int unsigned PTR_MAX_W          = 32;

    // Modulo-2^pw difference; callers cast the result down to their pointer width.
    function automatic logic [PTR_MAX_W-1:0] ptr_diff(input logic [PTR_MAX_W-1:0] a,
                                                      input logic [PTR_MAX_W-1:0] b,
                                                      input int unsigned          pw);
        logic [PTR_MAX_W-1:0] mask;
        mask = (pw >= PTR_MAX_W) ? '1 : ((PTR_MAX_W'(1) << pw) - PTR_MAX_W'(1));
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/usb_packet_fifo_if.sv
// Endpoint-side bundle: write/commit/abort, read/ack/retry, flush and status.
interface usb_packet_fifo_if
    import usb_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_commit;
    logic                  wr_abort;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_ack;
    logic                  rd_retry;
    logic                  flush;
    logic [AW:0]           buffer_occupancy;
    logic                  full;
    logic                  empty;
    logic                  overflow_err;
    logic                  underflow_err;

    modport master (
        output wr_en, wr_data, wr_commit, wr_abort, rd_en, rd_ack, rd_retry, flush,
        input  rd_data, buffer_occupancy, full, empty, overflow_err, underflow_err
    );

    modport slave (
        input  wr_en, wr_data, wr_commit, wr_abort, rd_en, rd_ack, rd_retry, flush,
        output rd_data, buffer_occupancy, full, empty, overflow_err, underflow_err
    );

endinterface

// File: rtl/usb_packet_fifo_mem.sv
// Register array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
    import usb_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]    rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/usb_packet_fifo.sv
// Packet-aware endpoint FIFO: write commit/abort, read ack/retry, sticky error flags.
module usb_packet_fifo
    import usb_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              n_rst,
    usb_packet_fifo_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [AW:0] DEPTH_P = PW'(DEPTH);

    typedef logic [AW:0] ptr_t;

    ptr_t wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, ack_q, ack_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    ptr_t occ;
    logic full, empty, wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd;

    always_comb begin
        occ    = PW'(ptr_diff(32'(cm_q), 32'(rd_q), PW));
        full   = (PW'(ptr_diff(32'(wr_q), 32'(ack_q), PW)) == DEPTH_P);
        empty  = (occ == '0);
        // Accept checks use registered full/empty only; abort/retry/flush suppress the strobe.
        wr_acc = bus.wr_en && !full && !bus.wr_abort && !bus.flush;
        rd_acc = bus.rd_en && !empty && !bus.rd_retry && !bus.flush;

        wr_d  = wr_q;
        cm_d  = cm_q;
        rd_d  = rd_q;
        ack_d = ack_q;
        ovf_d = ovf_q;
        unf_d = unf_q;

        if (bus.flush) begin
            wr_d  = '0;
            cm_d  = '0;
            rd_d  = '0;
            ack_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (bus.wr_abort) begin
                wr_d = cm_q;
            end else begin
                wr_d = wr_q + PW'(wr_acc);
                if (bus.wr_commit) cm_d = wr_d;
                if (bus.wr_en && full) ovf_d = 1'b1;
            end
            if (bus.rd_retry) begin
                rd_d = ack_q;
            end else begin
                rd_d = rd_q + PW'(rd_acc);
                if (bus.rd_ack) ack_d = rd_d;
                if (bus.rd_en && empty) unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_q  <= '0;
            cm_q  <= '0;
            rd_q  <= '0;
            ack_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            cm_q  <= cm_d;
            rd_q  <= rd_d;
            ack_q <= ack_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i      (clk),
        .wr_en_i    (wr_acc),
        .wr_addr_i  (wr_q[AW-1:0]),
        .wr_data_i  (bus.wr_data),
        .rd_addr_i  (rd_q[AW-1:0]),
        .rd_data_o  (mem_rd)
    );

    assign bus.rd_data          = empty ? '0 : mem_rd;
    assign bus.buffer_occupancy = occ;
    assign bus.full             = full;
    assign bus.empty            = empty;
    assign bus.overflow_err     = ovf_q;
    assign bus.underflow_err    = unf_q;

endmodule
